// File: rtl/ps2_kbd_sequencer.sv
// ps2_kbd_sequencer
// Drives a PS/2 keyboard through its init sequence (reset 0xFF, ACK, BAT
// result) and LED updates (0xED, ACK, LED byte, ACK). In IDLE it forwards
// received scan codes. Every transmitted byte is retried on 0xFE or timeout
// up to MAX_RETRY times before the sequencer parks in ERROR.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   host_tx_data/req  byte + one-cycle request to the PS/2 host transmitter
//   host_tx_ready     pulse: device ACK bit seen, transmit complete
//   host_rx_data/rdy  byte received by the host + valid pulse
//   restart           pulse: rerun init (honoured in IDLE or ERROR only)
//   led_req/led_state pulse + {caps, num, scroll} LED update request
//   code_data/valid   last forwarded scan code + one-cycle valid pulse
//   busy, init_done, init_error  status flags
module ps2_kbd_sequencer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int BAT_CYCLES     = 50000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] host_tx_data,
    output logic       host_tx_req,
    input  logic       host_tx_ready,
    input  logic [7:0] host_rx_data,
    input  logic       host_rx_ready,
    input  logic       restart,
    input  logic       led_req,
    input  logic [2:0] led_state,
    output logic [7:0] code_data,
    output logic       code_valid,
    output logic       busy,
    output logic       init_done,
    output logic       init_error
);
    typedef enum logic [3:0] {
        INIT_TX, INIT_ACK, INIT_BAT, IDLE, LED_TX, LED_ACK, LEDD_TX, LEDD_ACK, ERROR
    } state_t;

    // The request cycle counts toward the ACK budget, so a resend is issued
    // exactly TIMEOUT_CYCLES cycles after the previous request.
    localparam logic [26:0] ACK_LOAD  = 27'(TIMEOUT_CYCLES - 2);
    localparam logic [26:0] BAT_LOAD  = 27'(BAT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t      state, state_nx;
    logic [26:0] timer, timer_val;
    logic [7:0]  retry, tx_byte;
    logic        pending, tx_seen, fa_seen;
    logic        timer_ld, retry_inc, retry_clr, set_done, do_restart, take_led;
    logic        rx_fa, rx_fe, rx_aa, rx_fc, in_tx, in_ack, ack_ok, expired;

    assign rx_fa   = host_rx_ready && (host_rx_data == 8'hFA);
    assign rx_fe   = host_rx_ready && (host_rx_data == 8'hFE);
    assign rx_aa   = host_rx_ready && (host_rx_data == 8'hAA);
    assign rx_fc   = host_rx_ready && (host_rx_data == 8'hFC);
    assign in_tx   = state inside {INIT_TX, LED_TX, LEDD_TX};
    assign in_ack  = state inside {INIT_ACK, LED_ACK, LEDD_ACK};
    assign expired = (timer == 27'd0);
    // ACK completes once both the transmit-done pulse and 0xFA have been seen,
    // in either order (a fast device may answer before the host reports done).
    assign ack_ok  = (tx_seen || host_tx_ready) && (fa_seen || rx_fa);

    // State is INIT_TX during reset, so the combinational outputs are gated
    // to keep the request quiet until rst falls.
    assign host_tx_req  = !rst && in_tx;
    assign busy         = !rst && !(state inside {IDLE, ERROR});
    always_comb begin
        host_tx_data = tx_byte;
        if (rst)                  host_tx_data = 8'h00;
        else if (state == INIT_TX) host_tx_data = 8'hFF;
        else if (state == LED_TX)  host_tx_data = 8'hED;
    end

    always_comb begin
        state_nx   = state;
        timer_ld   = 1'b0;
        timer_val  = ACK_LOAD;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        set_done   = 1'b0;
        do_restart = 1'b0;
        take_led   = 1'b0;
        case (state)
            INIT_TX: begin state_nx = INIT_ACK; timer_ld = 1'b1; end
            LED_TX:  begin state_nx = LED_ACK;  timer_ld = 1'b1; end
            LEDD_TX: begin state_nx = LEDD_ACK; timer_ld = 1'b1; end
            INIT_ACK, LED_ACK, LEDD_ACK: begin
                if (ack_ok) begin
                    case (state)
                        INIT_ACK: begin
                            state_nx  = INIT_BAT;
                            timer_ld  = 1'b1;
                            timer_val = BAT_LOAD;
                        end
                        LED_ACK:  begin state_nx = LEDD_TX; retry_clr = 1'b1; end
                        default:  state_nx = IDLE;
                    endcase
                end else if (rx_fe || expired) begin
                    if (retry >= RETRY_MAX) begin
                        state_nx = ERROR;
                    end else begin
                        retry_inc = 1'b1;
                        case (state)
                            INIT_ACK: state_nx = INIT_TX;
                            LED_ACK:  state_nx = LED_TX;
                            default:  state_nx = LEDD_TX;
                        endcase
                    end
                end
            end
            INIT_BAT: begin
                if (rx_aa) begin
                    state_nx = IDLE;
                    set_done = 1'b1;
                end else if (rx_fc || expired) begin
                    state_nx = ERROR;
                end
            end
            IDLE, ERROR: begin
                if (restart) begin
                    state_nx   = INIT_TX;
                    do_restart = 1'b1;
                    retry_clr  = 1'b1;
                end else if (state == IDLE && pending) begin
                    state_nx  = LED_TX;
                    take_led  = 1'b1;
                    retry_clr = 1'b1;
                end
            end
            default: state_nx = INIT_TX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT_TX;
            timer      <= 27'd0;
            retry      <= 8'd0;
            tx_byte    <= 8'h00;
            pending    <= 1'b0;
            tx_seen    <= 1'b0;
            fa_seen    <= 1'b0;
            code_data  <= 8'h00;
            code_valid <= 1'b0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
        end else begin
            state <= state_nx;

            if (timer_ld)             timer <= timer_val;
            else if (timer != 27'd0)  timer <= timer - 27'd1;

            if (retry_clr)      retry <= 8'd0;
            else if (retry_inc) retry <= retry + 8'd1;

            // LED byte is frozen at LEDD_TX entry so resends repeat it.
            if (state == LED_ACK && state_nx == LEDD_TX) tx_byte <= {5'b0, led_state};
            else if (state == INIT_TX)                    tx_byte <= 8'hFF;
            else if (state == LED_TX)                     tx_byte <= 8'hED;

            if (in_tx) begin
                tx_seen <= 1'b0;
                fa_seen <= 1'b0;
            end else if (in_ack) begin
                tx_seen <= tx_seen || host_tx_ready;
                fa_seen <= fa_seen || rx_fa;
            end

            // A new led_req wins over the clear, so a request arriving as the
            // previous one is consumed is not lost.
            if (do_restart)                     pending <= 1'b0;
            else if (led_req && state != ERROR) pending <= 1'b1;
            else if (take_led)                  pending <= 1'b0;

            code_valid <= (state == IDLE) && host_rx_ready;
            if (state == IDLE && host_rx_ready) code_data <= host_rx_data;

            if (do_restart || (state_nx == ERROR && state != ERROR)) init_done <= 1'b0;
            else if (set_done)                                        init_done <= 1'b1;

            if (do_restart)                                init_error <= 1'b0;
            else if (state_nx == ERROR && state != ERROR)  init_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_kbd_sequencer.sv
module tb_ps2_kbd_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] host_tx_data;
    logic       host_tx_req;
    logic       host_tx_ready;
    logic [7:0] host_rx_data;
    logic       host_rx_ready;
    logic       restart;
    logic       led_req;
    logic [2:0] led_state;
    logic [7:0] code_data;
    logic       code_valid;
    logic       busy, init_done, init_error;

    ps2_kbd_sequencer #(.TIMEOUT_CYCLES(100), .BAT_CYCLES(300), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst),
        .host_tx_data(host_tx_data), .host_tx_req(host_tx_req), .host_tx_ready(host_tx_ready),
        .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
        .restart(restart), .led_req(led_req), .led_state(led_state),
        .code_data(code_data), .code_valid(code_valid),
        .busy(busy), .init_done(init_done), .init_error(init_error)
    );

    always #5 clk = ~clk;

    // Behavioural model: expected byte stream to the transmitter, expected
    // forwarded scan codes, and the status flags the sequence must show.
    logic [7:0] exp_tx[$];
    logic [7:0] exp_code[$];
    logic       m_busy, m_done, m_err, chk_status;
    int total = 0, bad = 0;
    int cyc = 0, req_count = 0, ff_reqs = 0, last_req_cyc = 0, prev_req_cyc = 0;
    logic prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial forever begin
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (host_tx_req) begin
                check("req_gap", 32'(prev_req), 0);
                check("tx_expected", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    check("tx_data", 32'(host_tx_data), 32'(e));
                end
                if (host_tx_data == 8'hFF) ff_reqs++;
                req_count++;
                prev_req_cyc = last_req_cyc;
                last_req_cyc = cyc;
            end
            prev_req = host_tx_req;
            if (code_valid) begin
                check("code_expected", 32'(exp_code.size() > 0), 1);
                if (exp_code.size() > 0) begin
                    e = exp_code.pop_front();
                    check("code_data", 32'(code_data), 32'(e));
                end
            end
            if (chk_status) begin
                check("busy", 32'(busy), 32'(m_busy));
                check("init_done", 32'(init_done), 32'(m_done));
                check("init_error", 32'(init_error), 32'(m_err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic pulse_ready; host_tx_ready = 1'b1; tick; host_tx_ready = 1'b0; endtask
    task automatic pulse_restart; restart = 1'b1; tick; restart = 1'b0; endtask
    task automatic pulse_led; led_req = 1'b1; tick; led_req = 1'b0; endtask
    task automatic send_rx(input logic [7:0] b);
        host_rx_data = b; host_rx_ready = 1'b1; tick; host_rx_ready = 1'b0;
    endtask
    task automatic wait_req(input int budget);
        int start;
        start = req_count;
        for (int i = 0; i < budget && req_count == start; i++) tick;
        check("req_seen", 32'(req_count != start), 1);
    endtask
    // Answer an outstanding 0xFF request through to BAT success.
    task automatic finish_init(input bit fa_first);
        if (fa_first) begin send_rx(8'hFA); pulse_ready; end
        else begin pulse_ready; send_rx(8'hFA); end
        send_rx(8'hAA);
        m_busy = 1'b0; m_done = 1'b1; m_err = 1'b0;
    endtask

    initial begin
        int base;
        rst = 1'b1; host_tx_ready = 1'b0; host_rx_data = 8'h00; host_rx_ready = 1'b0;
        restart = 1'b0; led_req = 1'b0; led_state = 3'b000; chk_status = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
        repeat (3) tick;
        @(negedge clk);
        check("rst_req", 32'(host_tx_req), 0);
        check("rst_data", 32'(host_tx_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(init_done), 0);
        check("rst_code", 32'({code_valid, code_data}), 0);
        tick;

        // Plain init after reset release.
        exp_tx.push_back(8'hFF);
        rst = 1'b0; m_busy = 1'b1; chk_status = 1'b1;
        wait_req(5);
        finish_init(1'b0);
        @(negedge clk);
        check("init1_done", 32'(init_done), 1);
        check("init1_busy", 32'(busy), 0);
        tick;

        // Three 0xFE then success: four 0xFF requests in total.
        base = ff_reqs;
        exp_tx.push_back(8'hFF);
        pulse_restart; m_busy = 1'b1; m_done = 1'b0;
        wait_req(5);
        for (int k = 0; k < 3; k++) begin
            send_rx(8'hFE); exp_tx.push_back(8'hFF); wait_req(5);
        end
        check("retry_ff_count", 32'(ff_reqs - base), 4);
        finish_init(1'b0);

        // Four 0xFE: retries exhausted.
        exp_tx.push_back(8'hFF);
        pulse_restart; m_busy = 1'b1; m_done = 1'b0;
        wait_req(5);
        for (int k = 0; k < 3; k++) begin
            send_rx(8'hFE); exp_tx.push_back(8'hFF); wait_req(5);
        end
        send_rx(8'hFE);
        m_busy = 1'b0; m_err = 1'b1;
        @(negedge clk);
        check("fe4_error", 32'(init_error), 1);
        tick;

        // Restart out of ERROR; 0xFA arrives before the transmit-done pulse.
        exp_tx.push_back(8'hFF);
        pulse_restart; m_busy = 1'b1; m_err = 1'b0;
        wait_req(5);
        finish_init(1'b1);

        // Scan code forwarding in IDLE.
        exp_code.push_back(8'h1C);
        send_rx(8'h1C);
        @(negedge clk);
        check("code_pulse", 32'({code_valid, code_data}), 32'h11C);
        @(negedge clk);
        check("code_one_cycle", 32'(code_valid), 0);
        tick;

        // LED update 3'b101: 0xED then 0x05; a resend keeps the sampled byte.
        led_state = 3'b101; chk_status = 1'b0;
        exp_tx.push_back(8'hED);
        pulse_led;
        wait_req(6);
        m_busy = 1'b1; chk_status = 1'b1;
        pulse_ready;
        send_rx(8'h1C);
        exp_tx.push_back(8'h05);
        send_rx(8'hFA);
        wait_req(5);
        led_state = 3'b010;
        send_rx(8'hFE); exp_tx.push_back(8'h05); wait_req(5);
        send_rx(8'h33);
        pulse_ready;
        send_rx(8'hFA);
        m_busy = 1'b0;
        @(negedge clk);
        check("led_busy_after", 32'(busy), 0);
        check("led_code_held", 32'(code_data), 32'h1C);
        tick;

        // No response after 0xED: resend every 100 cycles, then ERROR.
        chk_status = 1'b0;
        exp_tx.push_back(8'hED);
        pulse_led;
        wait_req(6);
        m_busy = 1'b1; chk_status = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_tx.push_back(8'hED);
            wait_req(150);
            check("resend_interval", 32'(last_req_cyc - prev_req_cyc), 100);
        end
        repeat (95) tick;
        chk_status = 1'b0;
        repeat (10) tick;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b1; chk_status = 1'b1;
        repeat (120) tick;
        @(negedge clk);
        check("timeout_error", 32'(init_error), 1);
        tick;
        exp_tx.push_back(8'hFF);
        pulse_restart; m_busy = 1'b1; m_err = 1'b0;
        wait_req(5);

        // No BAT result: ERROR once the BAT window closes.
        pulse_ready;
        send_rx(8'hFA);
        repeat (280) tick;
        chk_status = 1'b0;
        repeat (40) tick;
        m_busy = 1'b0; m_err = 1'b1; chk_status = 1'b1;
        @(negedge clk);
        check("bat_timeout_error", 32'(init_error), 1);
        tick;

        // rst in the middle of a transaction restarts init.
        exp_tx.push_back(8'hFF);
        pulse_restart; m_busy = 1'b1; m_err = 1'b0;
        wait_req(5);
        pulse_ready;
        chk_status = 1'b0;
        rst = 1'b1;
        repeat (2) tick;
        exp_tx.push_back(8'hFF);
        rst = 1'b0; m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; chk_status = 1'b1;
        wait_req(5);
        finish_init(1'b0);
        @(negedge clk);
        check("final_done", 32'(init_done), 1);
        repeat (3) @(negedge clk);

        check("tx_queue_drained", 32'(exp_tx.size()), 0);
        check("code_queue_drained", 32'(exp_code.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_sequencer.md
PS2_KBD_SEQUENCER -- requirements
Module: ps2_kbd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max clk cycles to wait for transmit completion plus ACK.
REQ-002 SHALL have parameter BAT_CYCLES, default 50000000, max clk cycles to wait for the BAT result after the reset ACK.
REQ-003 SHALL have parameter MAX_RETRY, default 3, resends allowed per byte before error.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port host_tx_data  out  8  byte to the PS/2 host transmitter.
REQ-007 SHALL have port host_tx_req  out  1  transmit request to host, rising-edge significant.
REQ-008 SHALL have port host_tx_ready  in  1  one-cycle pulse: device ACK bit seen, transmit complete.
REQ-009 SHALL have port host_rx_data  in  8  byte received by host.
REQ-010 SHALL have port host_rx_ready  in  1  one-cycle pulse: host_rx_data valid.
REQ-011 SHALL have port restart  in  1  one-cycle pulse: rerun init sequence.
REQ-012 SHALL have port led_req  in  1  one-cycle pulse: update keyboard LEDs.
REQ-013 SHALL have port led_state  in  3  {caps, num, scroll} LED bits.
REQ-014 SHALL have port code_data  out  8  last scan code forwarded, held until next.
REQ-015 SHALL have port code_valid  out  1  one-cycle pulse per forwarded scan code.
REQ-016 SHALL have ports busy, init_done, init_error  out  1 each  status flags.

Function
REQ-017 SHALL implement states INIT_TX, INIT_ACK, INIT_BAT, IDLE, LED_TX, LED_ACK, LEDD_TX, LEDD_ACK, ERROR.
REQ-018 SHALL, in every *_TX state, drive host_tx_data then assert host_tx_req for exactly one cycle and move to the matching wait state next cycle; host_tx_req SHALL be low at least one cycle between requests.
REQ-019 SHALL send 0xFF in INIT_TX, 0xED in LED_TX, {5'b0, led_state} sampled at entry to LEDD_TX.
REQ-020 SHALL, in each *_ACK state, require host_tx_ready then host_rx_data==0xFA; 0xFA before host_tx_ready is also accepted.
REQ-021 SHALL, on 0xFA: INIT_ACK->INIT_BAT, LED_ACK->LEDD_TX, LEDD_ACK->IDLE.
REQ-022 SHALL, on 0xFE or timer expiry in a *_ACK state, increment retry count and re-enter the same *_TX state with the same byte; when the count would exceed MAX_RETRY, go to ERROR.
REQ-023 SHALL ignore other received bytes in *_ACK and INIT_BAT states (not forwarded).
REQ-024 SHALL, in INIT_BAT: 0xAA -> IDLE with init_done=1; 0xFC or BAT_CYCLES expiry -> ERROR.
REQ-025 SHALL clear the retry count on each new byte (entry to a *_TX state from another state) and reload the timer (TIMEOUT_CYCLES or BAT_CYCLES) on every *_TX->wait transition; timer 27 bits, counts down, expiry at zero.
REQ-026 SHALL, in IDLE, copy every host_rx_data byte to code_data and pulse code_valid the cycle after host_rx_ready.
REQ-027 SHALL latch led_req into a pending flag in any state except ERROR; IDLE with pending set SHALL go to LED_TX and clear the flag; led_req in the cycle pending is cleared SHALL re-set it.
REQ-028 SHALL, on restart in IDLE or ERROR, clear init_done, init_error, pending flag and go to INIT_TX; restart in other states SHALL be ignored.
REQ-029 SHALL set init_error=1 while in ERROR (sticky until restart/rst); init_done SHALL go 0 on entry to ERROR.
REQ-030 SHALL drive busy=1 in every state except IDLE and ERROR.
REQ-031 SHALL give restart priority over pending LED request when both occur in IDLE.

Reset
REQ-032 SHALL, while rst=1: state INIT_TX, host_tx_req=0, host_tx_data=0x00, code_data=0x00, code_valid=0, busy=0, init_done=0, init_error=0, pending=0, retry=0, timer=0.
REQ-033 SHALL, on the first cycle after rst falls, pulse host_tx_req with host_tx_data=0xFF; rst mid-transaction SHALL abandon it and restart init this way.

Verification
REQ-034 SHALL test: rst release; tx_ready, rx 0xFA, rx 0xAA -> one 0xFF request, then init_done=1, busy=0.
REQ-035 SHALL test: during INIT_ACK rx 0xFE three times then 0xFA -> four 0xFF requests, init completes; a fourth 0xFE -> ERROR, init_error=1.
REQ-036 SHALL test: IDLE, led_req with led_state=3'b101 -> requests 0xED then 0x05 each after 0xFA; busy high throughout, low after second 0xFA.
REQ-037 SHALL test: in IDLE rx 0x1C -> code_valid one cycle, code_data=0x1C; rx 0x1C during LED_ACK -> no code_valid.
REQ-038 SHALL test (TIMEOUT_CYCLES=100): no response after 0xED -> resend at 100-cycle intervals, ERROR after MAX_RETRY+1 sends; restart -> 0xFF request.
